// File: rtl/memgame_pkg.sv
// Shared types and default timing for the memory-game input path.
package memgame_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms debounce, 500 ms first repeat, 200 ms repeat period at 50 MHz
  localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;
  localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
  localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;

  // Debounced level is high from acceptance of a press until the release is confirmed
  function automatic logic is_level(btn_state_t s);
    return (s == HELD) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button two-flop synchronizer plus debounce FSM.
// o_state_c is the current FSM state; o_event is a registered one-cycle
// strobe on the edge a press is accepted.
module btn_debounce
  import memgame_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_n,
  output btn_state_t o_state_c,
  output logic       o_event
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  btn_state_t       r_state;
  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_event;
  logic             w_event_nxt;
  logic             w_pressed;

  // Two-flop synchronizer; resets to the released level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  // State, stability counter and event register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_event <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_event <= w_event_nxt;
    end
  end

  // Next state: any sample disagreeing with the pending direction restarts the wait
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_pressed) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!w_pressed) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_pressed) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: press event on the PRESS_WAIT -> HELD transition
  always_comb begin
    w_event_nxt = 1'b0;
    o_state_c   = r_state;
    if ((r_state == PRESS_WAIT) && w_pressed && (r_cnt == CNT_LAST)) begin
      w_event_nxt = 1'b1;
    end
  end

  assign o_event = r_event;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner: synchronises and debounces MOVE/SELECT, gates events
// with en, gives SELECT priority and registers all outputs.
// Optional build macro MOVE_AUTOREPEAT_EN adds MOVE auto-repeat while held.
module button_conditioner
  import memgame_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_move_n,
  input  logic btn_select_n,
  input  logic en,
  output logic move_pulse,
  output logic select_pulse,
  output logic move_level,
  output logic select_level
);

  // Elaboration-time parameter sanity
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD == 0) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_repeat
    $error("need REPEAT_DELAY >= 2 and 0 < REPEAT_PERIOD <= REPEAT_DELAY");
  end

  btn_state_t w_move_state;
  btn_state_t w_select_state;
  logic       w_move_event;
  logic       w_select_event;
  logic       w_move_any;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_move (
    .clk       (clk),
    .rst       (rst),
    .i_btn_n   (btn_move_n),
    .o_state_c (w_move_state),
    .o_event   (w_move_event)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_select (
    .clk       (clk),
    .rst       (rst),
    .i_btn_n   (btn_select_n),
    .o_state_c (w_select_state),
    .o_event   (w_select_event)
  );

`ifdef MOVE_AUTOREPEAT_EN
  localparam int unsigned      RPT_W      = $clog2(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             w_rpt_event;

  // Cycles spent in HELD; reload after each repeat so later ones follow every REPEAT_PERIOD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rpt_cnt <= '0;
    end else if (w_move_state != HELD) begin
      r_rpt_cnt <= '0;
    end else if (r_rpt_cnt == RPT_LAST) begin
      r_rpt_cnt <= RPT_RELOAD;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
    end
  end

  assign w_rpt_event = (w_move_state == HELD) && (r_rpt_cnt == RPT_LAST);
  assign w_move_any  = w_move_event | w_rpt_event;
`else
  assign w_move_any  = w_move_event;
`endif

  // Gated, select-prioritised output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_pulse   <= 1'b0;
      select_pulse <= 1'b0;
      move_level   <= 1'b0;
      select_level <= 1'b0;
    end else begin
      select_pulse <= w_select_event & en;
      move_pulse   <= w_move_any & en & ~w_select_event;
      move_level   <= is_level(w_move_state);
      select_level <= is_level(w_select_state);
    end
  end

endmodule
